// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: FSM states,
// opcode/funct values, ALU operation codes and datapath mux selects.
package mc_pkg;

  localparam int STATE_BITS = 4;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_EXEC_R   = 4'd2;
  localparam logic [3:0] ST_WB_R     = 4'd3;
  localparam logic [3:0] ST_EXEC_I   = 4'd4;
  localparam logic [3:0] ST_WB_I     = 4'd5;
  localparam logic [3:0] ST_MEM_ADDR = 4'd6;
  localparam logic [3:0] ST_MEM_RD   = 4'd7;
  localparam logic [3:0] ST_WB_MEM   = 4'd8;
  localparam logic [3:0] ST_MEM_WR   = 4'd9;
  localparam logic [3:0] ST_BRANCH   = 4'd10;
  localparam logic [3:0] ST_JUMP     = 4'd11;
  localparam logic [3:0] ST_TRAP     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] MEMTOREG_ALU = 2'd0;
  localparam logic [1:0] MEMTOREG_MEM = 2'd1;
  localparam logic [1:0] MEMTOREG_PC  = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_BOFF = 2'd3;

  typedef struct packed {
    logic alu_r;
    logic sub;
    logic alu_i;
    logic lui;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic link;
    logic jump_reg;
    logic legal;
  } instr_class_t;

  // Memory offsets and branch displacements are signed; ori's immediate is not.
  function automatic logic ext_sign(instr_class_t c);
    return c.load | c.store | c.branch;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational op/funct decode into the instruction-class flags that steer
// both the DECODE transition and the per-state outputs.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   funct,
  output instr_class_t cls
);

  logic rtype;
  logic nop;

  assign rtype = (op == OP_RTYPE);
  assign nop   = rtype && (funct == FN_SLL);

  always_comb begin
    cls          = '0;
    cls.alu_r    = rtype && ((funct == FN_ADDU) || (funct == FN_SUBU));
    cls.sub      = rtype && (funct == FN_SUBU);
    cls.jump_reg = rtype && (funct == FN_JR);
    cls.alu_i    = (op == OP_ORI) || (op == OP_LUI);
    cls.lui      = (op == OP_LUI);
    cls.load     = (op == OP_LW);
    cls.store    = (op == OP_SW);
    cls.branch   = (op == OP_BEQ);
    cls.link     = (op == OP_JAL);
    cls.jump     = (op == OP_J) || (op == OP_JAL) || cls.jump_reg;
    cls.legal    = cls.alu_r | cls.alu_i | cls.load | cls.store |
                   cls.branch | cls.jump | nop;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM (Moore outputs, qualified by mem_ready/zero).
// Optional macro MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: unsupported instructions trap.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic               IorD,
  output logic               ExtOp,
  output logic               illegal,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         PCSource,
  output logic [2:0]         ALUControl,
  output logic [STATE_W-1:0] state
);

  logic [STATE_BITS-1:0] cur;
  logic [STATE_BITS-1:0] nxt;
  instr_class_t          cls;

  mc_decode u_decode (
    .op    (op),
    .funct (funct),
    .cls   (cls)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= ST_FETCH;
    else        cur <= nxt;
  end

  assign state = STATE_W'(cur);

  always_comb begin
    nxt = cur;
    case (cur)
      ST_FETCH:    if (mem_ready) nxt = ST_DECODE;
      ST_DECODE: begin
        if (cls.alu_r)                  nxt = ST_EXEC_R;
        else if (cls.alu_i)             nxt = ST_EXEC_I;
        else if (cls.load || cls.store) nxt = ST_MEM_ADDR;
        else if (cls.branch)            nxt = ST_BRANCH;
        else if (cls.jump)              nxt = ST_JUMP;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        else if (!cls.legal)            nxt = ST_TRAP;
`else
        else if (!cls.legal)            nxt = ST_FETCH;
`endif
        else                            nxt = ST_FETCH;
      end
      ST_EXEC_R:   nxt = ST_WB_R;
      ST_EXEC_I:   nxt = ST_WB_I;
      ST_MEM_ADDR: nxt = cls.load ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ready) nxt = ST_WB_MEM;
      ST_MEM_WR:   if (mem_ready) nxt = ST_FETCH;
      ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: nxt = ST_FETCH;
      ST_TRAP:     nxt = ST_TRAP;
      default:     nxt = ST_FETCH;
    endcase
  end

  // Outputs are forced low while reset is held so an aborted access never strobes.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    IorD       = 1'b0;
    ExtOp      = 1'b0;
    ALUSrcB    = SRCB_REG;
    RegDst     = REGDST_RT;
    MemtoReg   = MEMTOREG_ALU;
    PCSource   = PCSRC_ALU;
    ALUControl = ALU_ADD;
    if (reset) begin
      if ((cur != ST_FETCH) && (cur != ST_TRAP)) ExtOp = ext_sign(cls);
      case (cur)
        ST_FETCH: begin
          MemRead = 1'b1;
          if (mem_ready) begin
            IRWrite  = 1'b1;
            PCWrite  = 1'b1;
            ALUSrcB  = SRCB_FOUR;
          end
        end
        ST_DECODE: ALUSrcB = SRCB_BOFF;
        ST_EXEC_R: begin
          ALUSrcA    = 1'b1;
          ALUControl = cls.sub ? ALU_SUB : ALU_ADD;
        end
        ST_WB_R: begin
          RegWrite = 1'b1;
          RegDst   = REGDST_RD;
        end
        ST_EXEC_I: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          ALUControl = cls.lui ? ALU_LUI : ALU_OR;
        end
        ST_WB_I:   RegWrite = 1'b1;
        ST_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        ST_MEM_RD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        ST_WB_MEM: begin
          RegWrite = 1'b1;
          MemtoReg = MEMTOREG_MEM;
        end
        ST_MEM_WR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        ST_BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUControl = ALU_SUB;
          PCSource   = PCSRC_ALUOUT;
          PCWrite    = zero;
        end
        ST_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = cls.jump_reg ? PCSRC_RS : PCSRC_JUMP;
          if (cls.link) begin
            RegWrite = 1'b1;
            RegDst   = REGDST_RA;
            MemtoReg = MEMTOREG_PC;
          end
        end
        ST_TRAP: ;
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  // TRAP is only left through reset, which makes the flag sticky.
  assign illegal = reset && (cur == ST_TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected cycle lists
// built from the instruction timing rules, driven with random waits and zero flag.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
  logic       ALUSrcA, IorD, ExtOp, illegal;
  logic [1:0] ALUSrcB, RegDst, MemtoReg, PCSource;
  logic [2:0] ALUControl;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .IorD(IorD), .ExtOp(ExtOp), .illegal(illegal),
    .ALUSrcB(ALUSrcB), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .PCSource(PCSource), .ALUControl(ALUControl), .state(state)
  );

  typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ,
                    K_J, K_JAL, K_JR, K_NOP, K_ILL} kind_t;

  typedef struct {
    logic [3:0]  st;
    logic [4:0]  strb;   // {PCWrite, IRWrite, MemRead, MemWrite, RegWrite}
    logic [13:0] mux;
    logic [13:0] care;
    logic        rdy;
    logic        z;
    logic        ill;
  } cyc_t;

  localparam logic [4:0] S_PC = 5'b10000, S_IR = 5'b01000, S_MR = 5'b00100,
                         S_MW = 5'b00010, S_RW = 5'b00001;
  // mux layout {RegDst, MemtoReg, PCSource, ALUControl, IorD, ALUSrcA, ALUSrcB, ExtOp}
  localparam logic [13:0] C_RD = 14'b11_00_00_000_0_0_00_0;
  localparam logic [13:0] C_MT = 14'b00_11_00_000_0_0_00_0;
  localparam logic [13:0] C_PS = 14'b00_00_11_000_0_0_00_0;
  localparam logic [13:0] C_AC = 14'b00_00_00_111_0_0_00_0;
  localparam logic [13:0] C_IO = 14'b00_00_00_000_1_0_00_0;
  localparam logic [13:0] C_SA = 14'b00_00_00_000_0_1_00_0;
  localparam logic [13:0] C_SB = 14'b00_00_00_000_0_0_11_0;
  localparam logic [13:0] C_EO = 14'b00_00_00_000_0_0_00_1;

  cyc_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [13:0] mx(input logic [1:0] rd, input logic [1:0] mt,
                                     input logic [1:0] ps, input logic [2:0] ac,
                                     input logic io, input logic sa,
                                     input logic [1:0] sb, input logic eo);
    return {rd, mt, ps, ac, io, sa, sb, eo};
  endfunction

  function automatic void add(input logic [3:0] st, input logic [4:0] strb,
                              input logic [13:0] m, input logic [13:0] care,
                              input logic rdy, input logic z, input logic ill);
    cyc_t c;
    c.st = st; c.strb = strb; c.mux = m; c.care = care;
    c.rdy = rdy; c.z = z; c.ill = ill;
    exp_q.push_back(c);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1));
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, including its fetch.
  function automatic void build(input kind_t k, input logic z, input int wf, input int wm);
    exp_q.delete();
    for (int i = 0; i < wf; i++) add(ST_FETCH, S_MR, '0, C_IO, 1'b0, z, 1'b0);
    add(ST_FETCH, S_PC | S_IR | S_MR, mx(0, 0, 0, 0, 0, 0, 1, 0),
        C_PS | C_AC | C_IO | C_SA | C_SB, 1'b1, z, 1'b0);
    add(ST_DECODE, 5'b0, mx(0, 0, 0, 0, 0, 0, 3, 0), C_AC | C_SA | C_SB, rb(), z, 1'b0);
    case (k)
      K_ADDU, K_SUBU: begin
        add(ST_EXEC_R, 5'b0, mx(0, 0, 0, (k == K_SUBU) ? 3'd1 : 3'd0, 0, 1, 0, 0),
            C_AC | C_SA | C_SB, rb(), z, 1'b0);
        add(ST_WB_R, S_RW, mx(1, 0, 0, 0, 0, 0, 0, 0), C_RD | C_MT, rb(), z, 1'b0);
      end
      K_ORI, K_LUI: begin
        add(ST_EXEC_I, 5'b0, mx(0, 0, 0, (k == K_LUI) ? 3'd3 : 3'd2, 0, 1, 2, 0),
            C_AC | C_SA | C_SB | ((k == K_ORI) ? C_EO : 14'b0), rb(), z, 1'b0);
        add(ST_WB_I, S_RW, mx(0, 0, 0, 0, 0, 0, 0, 0), C_RD | C_MT, rb(), z, 1'b0);
      end
      K_LW, K_SW: begin
        add(ST_MEM_ADDR, 5'b0, mx(0, 0, 0, 0, 0, 1, 2, 1), C_AC | C_SA | C_SB | C_EO,
            rb(), z, 1'b0);
        for (int i = 0; i <= wm; i++) begin
          if (k == K_LW) add(ST_MEM_RD, S_MR, mx(0, 0, 0, 0, 1, 0, 0, 0), C_IO, i == wm, z, 1'b0);
          else           add(ST_MEM_WR, S_MW, '0, '0, i == wm, z, 1'b0);
        end
        if (k == K_LW)
          add(ST_WB_MEM, S_RW, mx(0, 1, 0, 0, 0, 0, 0, 0), C_RD | C_MT, rb(), z, 1'b0);
      end
      K_BEQ: add(ST_BRANCH, z ? S_PC : 5'b0, mx(0, 0, 1, 1, 0, 0, 0, 1),
                 C_PS | C_AC | C_EO, rb(), z, 1'b0);
      K_J:   add(ST_JUMP, S_PC, mx(0, 0, 2, 0, 0, 0, 0, 0), C_PS, rb(), z, 1'b0);
      K_JAL: add(ST_JUMP, S_PC | S_RW, mx(2, 2, 2, 0, 0, 0, 0, 0), C_RD | C_MT | C_PS,
                 rb(), z, 1'b0);
      K_JR:  add(ST_JUMP, S_PC, mx(0, 0, 3, 0, 0, 0, 0, 0), C_PS, rb(), z, 1'b0);
      K_ILL: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) add(ST_TRAP, 5'b0, '0, '0, rb(), z, 1'b1);
`endif
      end
      default: ;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {PCWrite, IRWrite, MemRead, MemWrite, RegWrite};
  endfunction

  task automatic set_instr(input kind_t k);
    funct = 6'($urandom_range(63));
    case (k)
      K_ADDU: begin op = 6'h00; funct = 6'h21; end
      K_SUBU: begin op = 6'h00; funct = 6'h23; end
      K_ORI:  op = 6'h0D;
      K_LUI:  op = 6'h0F;
      K_LW:   op = 6'h23;
      K_SW:   op = 6'h2B;
      K_BEQ:  op = 6'h04;
      K_J:    op = 6'h02;
      K_JAL:  op = 6'h03;
      K_JR:   begin op = 6'h00; funct = 6'h08; end
      K_NOP:  begin op = 6'h00; funct = 6'h00; end
      default: op = 6'h3F;
    endcase
  endtask

  // Runs the first ncyc expected cycles (all of them when ncyc < 0).
  task automatic run(input kind_t k, input logic z, input int wf, input int wm, input int ncyc);
    int   n;
    cyc_t c;
    build(k, z, wf, wm);
    set_instr(k);
    n = (ncyc < 0) ? exp_q.size() : ncyc;
    for (int i = 0; i < n; i++) begin
      c = exp_q[i];
      mem_ready = c.rdy;
      zero      = c.z;
      #2;
      check($sformatf("%s.c%0d.state", k.name(), i), 32'(state), 32'(c.st));
      check($sformatf("%s.c%0d.strobes", k.name(), i), 32'(strobes()), 32'(c.strb));
      if (c.care != '0)
        check($sformatf("%s.c%0d.mux", k.name(), i),
              32'(mx(RegDst, MemtoReg, PCSource, ALUControl, IorD, ALUSrcA, ALUSrcB, ExtOp) & c.care),
              32'(c.mux & c.care));
      check($sformatf("%s.c%0d.illegal", k.name(), i), 32'(illegal), 32'(c.ill));
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    #1;
    check({tag, ".state"}, 32'(state), 32'(ST_FETCH));
    check({tag, ".strobes"}, 32'(strobes()), 32'd0);
    check({tag, ".illegal"}, 32'(illegal), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    kind_t k;
    reset = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = 6'h00; funct = 6'h00;
    repeat (2) @(posedge clk);
    #1;
    pulse_reset("reset");

    run(K_ADDU, 1'b0, 0, 0, -1);
    run(K_LW,   1'b0, 0, 2, -1);
    run(K_BEQ,  1'b1, 0, 0, -1);
    run(K_BEQ,  1'b0, 0, 0, -1);
    run(K_JAL,  1'b0, 1, 0, -1);
    run(K_SW,   1'b1, 0, 1, -1);
    run(K_SUBU, 1'b0, 2, 0, -1);
    run(K_ORI,  1'b0, 0, 0, -1);
    run(K_LUI,  1'b1, 0, 0, -1);
    run(K_J,    1'b0, 0, 0, -1);
    run(K_JR,   1'b1, 0, 0, -1);
    run(K_NOP,  1'b0, 0, 0, -1);

    // Abort a store that is still waiting on memory.
    run(K_SW, 1'b0, 0, 3, 3);
    mem_ready = 1'b0;
    #2;
    check("abort.pre.state", 32'(state), 32'(ST_MEM_WR));
    check("abort.pre.memwrite", 32'(MemWrite), 32'd1);
    #1;
    pulse_reset("abort");
    run(K_ADDU, 1'b0, 0, 0, -1);

    for (int i = 0; i < 40; i++) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      k = kind_t'($urandom_range(int'(K_NOP)));
`else
      k = kind_t'($urandom_range(int'(K_ILL)));
`endif
      run(k, rb(), $urandom_range(2), $urandom_range(2), -1);
    end

    run(K_ILL, 1'b0, 0, 0, -1);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    pulse_reset("trap.reset");
`endif
    run(K_ADDU, 1'b1, 1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter STATE_W, default 4, width of the state encoding and of the state output.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 op  input  6  IR[31:26], sampled from the instruction register.
REQ-005 funct  input  6  IR[5:0].
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory handshake; the access completes in the cycle where it is 1.
REQ-008 Outputs, each 1 bit: PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUSrcA, IorD, ExtOp, illegal.
REQ-009 Outputs, 2 bits: ALUSrcB, RegDst (0 rt, 1 rd, 2 $31), MemtoReg (0 ALU, 1 mem, 2 PC), PCSource (0 ALU, 1 ALUOut, 2 jump target, 3 rs).
REQ-010 Output ALUControl, 3 bits: 0 add, 1 sub, 2 or, 3 lui.
REQ-011 Output state, STATE_W bits: current state, for debug.

Function
REQ-012 Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr. The opcode/funct value 0/0 (sll $0 = nop) is legal and writes nothing.
REQ-013 States and transitions:
- FETCH -> DECODE.
- DECODE -> EXEC_R (addu/subu), EXEC_I (ori/lui), MEM_ADDR (lw/sw), BRANCH (beq), JUMP (j/jal/jr), FETCH (nop).
- EXEC_R -> WB_R.
- EXEC_I -> WB_I.
- MEM_ADDR -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD -> WB_MEM.
- WB_R, WB_I, WB_MEM, MEM_WR, BRANCH, JUMP -> FETCH.
REQ-014 FETCH: IorD=0 and MemRead=1 while waiting. In the mem_ready cycle: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=1 (constant 4), ALUControl=add, PCSource=0. Stay in FETCH while mem_ready=0.
REQ-015 DECODE: compute the branch target with ALUSrcA=0, ALUSrcB=3 (sign-extended offset shifted left 2), ALUControl=add. No architectural write.
REQ-016 MEM_RD: IorD=1, MemRead=1 until mem_ready. MEM_WR: MemWrite=1 until mem_ready. Each state holds while mem_ready=0; MemWrite is never asserted for more than one accepted access.
REQ-017 BRANCH: ALUControl=sub and PCSource=1. PCWrite=zero.
REQ-018 JUMP:
- j: PCSource=2, PCWrite=1.
- jal: additionally RegWrite=1, RegDst=2, MemtoReg=2.
- jr: PCSource=3, PCWrite=1.
REQ-019 ExtOp=0 (zero-extend) for ori. ExtOp=1 for lw, sw and beq.
REQ-020 Every strobe not explicitly listed for a state is 0.
REQ-021 Latency in cycles, with zero memory wait: R/I-type 4, lw 5, sw 4, beq 3, j/jal/jr 3. Each memory wait cycle adds 1.
REQ-022 The outputs are a Moore decode of state, qualified by mem_ready and zero where stated above.

Reset
REQ-023 When reset=0: state=FETCH immediately (asynchronous), all strobes 0, illegal=0.
REQ-024 Reset asserted mid-instruction aborts the instruction with no partial register or memory write. The first cycle after release is FETCH.

Configuration
REQ-025 Macro MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unsupported op/funct in DECODE enters TRAP. TRAP sets illegal=1 (sticky), holds all strobes 0, and is left only by reset.
- Undefined: an unsupported op/funct is treated as nop (DECODE -> FETCH), and illegal is tied to 0.

Structure
REQ-026 Shared package mc_pkg holds:
- state encoding localparams;
- opcode/funct constants;
- ALUControl codes;
- RegDst, MemtoReg and PCSource codes.
REQ-027 One sub-module, mc_decode: combinational op/funct decode into instruction-class flags, used by the DECODE transition and by the per-state output logic.

Verification
REQ-028 addu (op=0, funct=0x21) with mem_ready=1 always -> states FETCH, DECODE, EXEC_R, WB_R. WB_R asserts RegWrite=1, RegDst=1, MemtoReg=0. Total 4 cycles.
REQ-029 lw (op=0x23) with mem_ready held 0 for 2 cycles in MEM_RD -> MEM_RD lasts 3 cycles with IorD=1. Then WB_MEM asserts RegWrite=1, MemtoReg=1, RegDst=0.
REQ-030 beq (op=0x04):
- zero=1 -> PCWrite=1, PCSource=1 in BRANCH.
- zero=0 -> PCWrite=0.
- Either case returns to FETCH next cycle.
REQ-031 jal (op=0x03) -> JUMP asserts PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemtoReg=2.
REQ-032 reset=0 asserted during MEM_WR with mem_ready=0 -> state=FETCH and MemWrite=0 within the same cycle. No write is accepted after release.
REQ-033 op=0x3F:
- With the macro defined -> TRAP; illegal=1 persists until reset.
- Without the macro -> FETCH follows DECODE and illegal=0.
